// File: rtl/munoc_error_reporter.sv
// munoc_error_reporter
//   Collects sticky error flags from NUM_SRC upstream protocol monitors and
//   turns each rising edge into a queued report. Reports are presented one
//   at a time, lowest source index first, with a valid/ack handshake and an
//   interrupt line. A saturating event counter and a sticky overflow flag
//   record how many events were seen and whether any were lost.
//
// Ports
//   clk         rising-edge clock
//   rstnn       asynchronous active-low reset
//   enable      gates every non-reset state update
//   src_error   level error flags, one per source
//   src_info    per-source info, source i at [i*INFO_WIDTH +: INFO_WIDTH]
//   err_ack     consumer acknowledge of the presented report
//   clear_stat  clears err_count and overflow
//   err_valid   a report is presented
//   err_src     index of the reported source
//   err_info    info captured with the reported event
//   irq         interrupt, same as err_valid
//   err_count   saturating count of detected events
//   overflow    sticky: an event arrived while its source was still pending
module munoc_error_reporter #(
    parameter int  NUM_SRC    = 4,
    parameter int  INFO_WIDTH = 8,
    parameter int  CNT_WIDTH  = 8,
    localparam int SW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rstnn,
    input  logic                          enable,
    input  logic [NUM_SRC-1:0]            src_error,
    input  logic [NUM_SRC*INFO_WIDTH-1:0] src_info,
    input  logic                          err_ack,
    input  logic                          clear_stat,
    output logic                          err_valid,
    output logic [SW-1:0]                 err_src,
    output logic [INFO_WIDTH-1:0]         err_info,
    output logic                          irq,
    output logic [CNT_WIDTH-1:0]          err_count,
    output logic                          overflow
);

    localparam int PCW  = $clog2(NUM_SRC + 1);
    localparam int SUMW = CNT_WIDTH + PCW;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

    // Number of set bits in an event vector.
    function automatic logic [PCW-1:0] popcount(input logic [NUM_SRC-1:0] v);
        logic [PCW-1:0] cnt;
        cnt = {PCW{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt = cnt + {{(PCW-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Counter add that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] base,
                                                     input logic [PCW-1:0]       n);
        logic [SUMW-1:0] sum;
        sum = {{PCW{1'b0}}, base} + {{CNT_WIDTH{1'b0}}, n};
        if (sum[SUMW-1:CNT_WIDTH] != {PCW{1'b0}}) begin
            return {CNT_WIDTH{1'b1}};
        end else begin
            return sum[CNT_WIDTH-1:0];
        end
    endfunction

    state_t                  state_q, state_d;
    logic [NUM_SRC-1:0]      src_prev_q, src_prev_d;
    logic [NUM_SRC-1:0]      pending_q, pending_d;
    logic [INFO_WIDTH-1:0]   info_buf_q [NUM_SRC];
    logic [INFO_WIDTH-1:0]   info_buf_d [NUM_SRC];
    logic                    err_valid_q, err_valid_d;
    logic [SW-1:0]           err_src_q, err_src_d;
    logic [INFO_WIDTH-1:0]   err_info_q, err_info_d;
    logic [CNT_WIDTH-1:0]    err_count_q, err_count_d;
    logic                    overflow_q, overflow_d;

    logic [NUM_SRC-1:0]      rise_s;
    logic [NUM_SRC-1:0]      lowest_s;
    logic [NUM_SRC-1:0]      sel_mask_s;
    logic [NUM_SRC-1:0]      lost_s;
    logic [SW-1:0]           lowest_idx_s;
    logic                    found_s;
    logic [CNT_WIDTH-1:0]    cnt_base_s;

    // Priority pick of the lowest pending source (index and one-hot form).
    always_comb begin
        lowest_s     = {NUM_SRC{1'b0}};
        lowest_idx_s = {SW{1'b0}};
        found_s      = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending_q[i] && !found_s) begin
                found_s      = 1'b1;
                lowest_s[i]  = 1'b1;
                lowest_idx_s = SW'(i);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic: edge detection, pending/info capture, FSM, statistics.
    always_comb begin
        rise_s      = src_error & ~src_prev_q;
        sel_mask_s  = {NUM_SRC{1'b0}};
        lost_s      = {NUM_SRC{1'b0}};
        cnt_base_s  = err_count_q;
        state_d     = state_q;
        src_prev_d  = src_prev_q;
        pending_d   = pending_q;
        info_buf_d  = info_buf_q;
        err_src_d   = err_src_q;
        err_info_d  = err_info_q;
        err_count_d = err_count_q;
        overflow_d  = overflow_q;

        if (enable) begin
            src_prev_d = src_error;

            case (state_q)
                ST_IDLE: begin
                    if (pending_q != {NUM_SRC{1'b0}}) begin
                        sel_mask_s = lowest_s;
                        err_src_d  = lowest_idx_s;
                        err_info_d = info_buf_q[lowest_idx_s];
                        state_d    = ST_REPORT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REPORT: begin
                    if (err_ack) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_REPORT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // A source being selected this cycle is no longer pending, so a
            // coincident rise re-arms it with fresh info instead of being lost.
            lost_s = rise_s & pending_q & ~sel_mask_s;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (rise_s[i] && !lost_s[i]) begin
                    info_buf_d[i] = src_info[i*INFO_WIDTH +: INFO_WIDTH];
                end else begin
                    info_buf_d[i] = info_buf_q[i];
                end
            end
            pending_d = (pending_q & ~sel_mask_s) | rise_s;

            // clear_stat restarts the statistics but still counts this cycle's events.
            if (clear_stat) begin
                cnt_base_s = {CNT_WIDTH{1'b0}};
                overflow_d = 1'b0;
            end else begin
                cnt_base_s = err_count_q;
                overflow_d = overflow_q | (lost_s != {NUM_SRC{1'b0}});
            end
            err_count_d = sat_add(cnt_base_s, popcount(rise_s));
        end else begin
            state_d = state_q;
        end

        err_valid_d = (state_d == ST_REPORT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q     <= ST_IDLE;
            src_prev_q  <= {NUM_SRC{1'b0}};
            pending_q   <= {NUM_SRC{1'b0}};
            info_buf_q  <= '{default: {INFO_WIDTH{1'b0}}};
            err_valid_q <= 1'b0;
            err_src_q   <= {SW{1'b0}};
            err_info_q  <= {INFO_WIDTH{1'b0}};
            err_count_q <= {CNT_WIDTH{1'b0}};
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_prev_q  <= src_prev_d;
            pending_q   <= pending_d;
            info_buf_q  <= info_buf_d;
            err_valid_q <= err_valid_d;
            err_src_q   <= err_src_d;
            err_info_q  <= err_info_d;
            err_count_q <= err_count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign err_valid = err_valid_q;
    assign irq       = err_valid_q;
    assign err_src   = err_src_q;
    assign err_info  = err_info_q;
    assign err_count = err_count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_munoc_error_reporter.sv
// Testbench for munoc_error_reporter: directed stimulus pushes expected
// reports into a scoreboard queue; a monitor pops and compares each report
// as the DUT presents it, and acknowledges it when auto_ack is set.
module tb_munoc_error_reporter;

    localparam int NUM_SRC    = 4;
    localparam int INFO_WIDTH = 8;
    localparam int CNT_WIDTH  = 8;
    localparam int SW         = 2;

    logic                          clk = 1'b0;
    logic                          rstnn;
    logic                          enable;
    logic [NUM_SRC-1:0]            src_error;
    logic [NUM_SRC*INFO_WIDTH-1:0] src_info;
    logic                          err_ack;
    logic                          clear_stat;
    logic                          err_valid;
    logic [SW-1:0]                 err_src;
    logic [INFO_WIDTH-1:0]         err_info;
    logic                          irq;
    logic [CNT_WIDTH-1:0]          err_count;
    logic                          overflow;

    typedef struct packed {
        logic [SW-1:0]         src;
        logic [INFO_WIDTH-1:0] info;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic auto_ack   = 1'b1;

    munoc_error_reporter #(
        .NUM_SRC   (NUM_SRC),
        .INFO_WIDTH(INFO_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .rstnn     (rstnn),
        .enable    (enable),
        .src_error (src_error),
        .src_info  (src_info),
        .err_ack   (err_ack),
        .clear_stat(clear_stat),
        .err_valid (err_valid),
        .err_src   (err_src),
        .err_info  (err_info),
        .irq       (irq),
        .err_count (err_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int s, input logic [7:0] inf);
        exp_t e;
        e.src  = SW'(s);
        e.info = inf;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_info(input int s, input logic [7:0] v);
        src_info[s*INFO_WIDTH +: INFO_WIDTH] = v;
    endtask

    task automatic pulse_clear();
        step();
        clear_stat = 1'b1;
        step();
        clear_stat = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || err_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (sb_q.size() != 0 || err_valid) begin
            mismatched++;
            $display("FAIL drain_%s: %0d reports outstanding, expected 0", name, sb_q.size());
        end
    endtask

    // Monitor: compare each presented report against the scoreboard.
    initial begin : monitor
        exp_t cur;
        bit   seen;
        bit   have_cur;
        seen     = 1'b0;
        have_cur = 1'b0;
        err_ack  = 1'b0;
        forever begin
            @(negedge clk);
            if (err_valid) begin
                chk("irq_high", irq, 1);
                if (!seen) begin
                    seen = 1'b1;
                    if (sb_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        have_cur = 1'b0;
                        $display("FAIL unexpected_report: got src %0d info 0x%0h, expected none",
                                 err_src, err_info);
                    end else begin
                        cur      = sb_q.pop_front();
                        have_cur = 1'b1;
                        chk("err_src", err_src, cur.src);
                        chk("err_info", err_info, cur.info);
                    end
                end else if (have_cur) begin
                    chk("err_src_stable", err_src, cur.src);
                    chk("err_info_stable", err_info, cur.info);
                end
                err_ack = auto_ack;
            end else begin
                chk("irq_low", irq, 0);
                seen     = 1'b0;
                have_cur = 1'b0;
                err_ack  = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rstnn      = 1'b0;
        enable     = 1'b0;
        src_error  = 4'b0000;
        src_info   = 32'h0000_0000;
        clear_stat = 1'b0;
        #1;
        chk("rst_valid", err_valid, 0);
        chk("rst_irq", irq, 0);
        chk("rst_src", err_src, 0);
        chk("rst_info", err_info, 0);
        chk("rst_count", err_count, 0);
        chk("rst_overflow", overflow, 0);
        step();
        step();
        rstnn  = 1'b1;
        enable = 1'b1;
        step();
        step();

        // Single error: latency 2, then ack drops valid next cycle.
        set_info(2, 8'h5A);
        src_error[2] = 1'b1;
        push(2, 8'h5A);
        @(negedge clk); chk("t1_valid_N", err_valid, 0);
        @(negedge clk); chk("t1_valid_N1", err_valid, 0);
        @(negedge clk); chk("t1_valid_N2", err_valid, 1);
        chk("t1_count", err_count, 1);
        @(negedge clk); chk("t1_valid_after_ack", err_valid, 0);
        step();
        src_error = 4'b0000;
        drain("t1");

        // Simultaneous rises: lower index first, gap, then the other.
        pulse_clear();
        set_info(1, 8'h11);
        set_info(3, 8'h33);
        push(1, 8'h11);
        push(3, 8'h33);
        src_error = 4'b1010;
        drain("t2");
        chk("t2_count", err_count, 2);
        src_error = 4'b0000;
        step();

        // Overflow: source 0 rises twice while the FSM is busy with source 3.
        auto_ack = 1'b0;
        push(3, 8'h33);
        src_error[3] = 1'b1;
        step(); step(); step();
        @(negedge clk); chk("t3_holding", err_valid, 1);
        pulse_clear();
        push(0, 8'h11);
        set_info(0, 8'h11);
        src_error[0] = 1'b1;
        step();
        src_error[0] = 1'b0;
        set_info(0, 8'h22);
        step();
        src_error[0] = 1'b1;
        step();
        src_error[0] = 1'b0;
        @(negedge clk);
        chk("t3_overflow", overflow, 1);
        chk("t3_count", err_count, 2);
        auto_ack     = 1'b1;
        src_error[3] = 1'b0;
        drain("t3");

        // Saturation: 300 events on source 0, one report each.
        for (int k = 0; k < 300; k++) begin
            set_info(0, 8'(k));
            src_error[0] = 1'b1;
            push(0, 8'(k));
            step(); step();
            src_error[0] = 1'b0;
            step(); step();
        end
        drain("t4");
        chk("t4_count_sat", err_count, 255);
        chk("t4_overflow_kept", overflow, 1);

        // clear_stat coinciding with two rises.
        set_info(1, 8'hA1);
        set_info(2, 8'hA2);
        push(1, 8'hA1);
        push(2, 8'hA2);
        clear_stat = 1'b1;
        src_error  = 4'b0110;
        step();
        clear_stat = 1'b0;
        @(negedge clk);
        chk("t4_clear_count", err_count, 2);
        chk("t4_clear_overflow", overflow, 0);
        drain("t4b");
        src_error = 4'b0000;
        pulse_clear();
        @(negedge clk);
        chk("t4_cleared_count", err_count, 0);
        chk("t4_cleared_overflow", overflow, 0);

        // enable=0 freezes everything; re-enable gives exactly one report.
        step();
        enable = 1'b0;
        step();
        set_info(1, 8'h5B);
        src_error[1] = 1'b1;
        repeat (5) step();
        @(negedge clk);
        chk("t5_frozen_valid", err_valid, 0);
        chk("t5_frozen_count", err_count, 0);
        push(1, 8'h5B);
        step();
        enable = 1'b1;
        drain("t5");
        repeat (10) step();
        chk("t5_count", err_count, 1);
        chk("t5_no_extra", sb_q.size(), 0);
        src_error = 4'b0000;
        step();

        // Reset during REPORT drops it; all-ones afterwards reports in order.
        auto_ack = 1'b0;
        set_info(0, 8'h77);
        push(0, 8'h77);
        src_error[0] = 1'b1;
        for (int i = 0; i < 10 && !err_valid; i++) @(negedge clk);
        chk("t6_valid_before_rst", err_valid, 1);
        #2;
        rstnn = 1'b0;
        #1;
        chk("t6_rst_valid", err_valid, 0);
        chk("t6_rst_irq", irq, 0);
        chk("t6_rst_count", err_count, 0);
        src_error = 4'b1111;
        for (int i = 0; i < NUM_SRC; i++) begin
            set_info(i, 8'hC0 + 8'(i));
            push(i, 8'hC0 + 8'(i));
        end
        auto_ack = 1'b1;
        step(); step();
        rstnn = 1'b1;
        drain("t6");
        chk("t6_count", err_count, 4);
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
